// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder: FSM state encoding,
// the decimal digit limit and the +6 correction applied on digit overflow.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  // Wraps modulo 16, so an illegal digit still yields a defined value.
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

  function automatic logic digit_bad(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal correction; purely combinational and
// time-shared across all digit positions by the serial controller.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    if (t > {1'b0, BCD_MAX}) begin
      s  = 4'(t + {1'b0, BCD_CORR});
      co = 1'b1;
    end else begin
      s  = t[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD add/subtract: one digit per clock, LSD first, using a
// single shared bcd_digit_add. Subtraction is a + nines(b) + 1.
//
// state   | meaning
// ST_IDLE | waiting for start; result registers hold last values
// ST_ADD  | processing digit idx_q of the latched operands
// ST_DONE | result valid, done pulses for this one cycle
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*N_DIGITS-1:0] a,
  input  logic [4*N_DIGITS-1:0] b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int W     = 4 * N_DIGITS;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             invalid_q, invalid_d;

  logic [3:0] a_dig, b_dig, bd_dig, dig_s;
  logic       dig_co;

  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  assign bd_dig = sub_q ? nines_comp(b_dig) : b_dig;

  bcd_digit_add u_digit_add (
    .a  (a_dig),
    .b  (bd_dig),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          sub_d     = sub;
          carry_d   = sub ? 1'b1 : cin;
          idx_d     = '0;
          sum_d     = '0;
          invalid_d = 1'b0;
          state_d   = ST_ADD;
        end
      end

      ST_ADD: begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[4*i +: 4] = dig_s;
        end
        // Validity is judged on the raw b digit, not its complement.
        invalid_d = invalid_q | digit_bad(a_dig) | digit_bad(b_dig);
        carry_d   = dig_co;
        idx_d     = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = dig_co;
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sub_q     <= sub_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (N_DIGITS=4) with hand-computed results.
module tb_bcd_serial_adder;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, sub, cin;
  logic [4*ND-1:0] a, b;
  logic          busy, done, cout, invalid;
  logic [4*ND-1:0] sum;

  int tests = 0;
  int fails = 0;
  int lat;

  bcd_serial_adder #(.N_DIGITS(ND)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; the following edge samples start.
  task automatic do_start(input logic s, input logic [15:0] av, input logic [15:0] bv,
                          input logic c);
    sub   = s;
    a     = av;
    b     = bv;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int already, output int edges);
    int k;
    k = already;
    while (!done && k < 12) begin
      tick();
      k++;
    end
    edges = k;
  endtask

  task automatic run_op(input string tag, input logic s, input logic [15:0] av,
                        input logic [15:0] bv, input logic c, input logic [15:0] es,
                        input logic ec, input logic ei);
    do_start(s, av, bv, c);
    check({tag, "_busy"}, busy, 1'b1);
    wait_done(0, lat);
    check({tag, "_lat"}, lat, ND);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_inv"}, invalid, ei);
    tick();
    check({tag, "_done_1cyc"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_inv", invalid, 1'b0);
    rst_n = 1'b1;
    tick();

    run_op("add_basic", 1'b0, 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("add_wrap",  1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_wrap_c",1'b0, 16'h9999, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0);
    run_op("sub_pos",   1'b1, 16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b1, 1'b0);
    // cin must be ignored in subtract mode
    run_op("sub_neg",   1'b1, 16'h1234, 16'h5000, 1'b1, 16'h6234, 1'b0, 1'b0);
    run_op("inv_set",   1'b0, 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1);
    run_op("inv_clr",   1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

    // Idle with start low: result holds even when inputs change
    a = 16'h7777;
    b = 16'h7777;
    tick();
    tick();
    check("hold_sum", sum, 16'h0003);
    check("hold_busy", busy, 1'b0);

    // Restart attempt two cycles in, with new operands, must be ignored
    do_start(1'b0, 16'h1111, 16'h2222, 1'b0);
    tick();
    a     = 16'h9999;
    b     = 16'h9999;
    cin   = 1'b1;
    sub   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(2, lat);
    check("busy_start_lat", lat, ND);
    check("busy_start_sum", sum, 16'h3333);
    check("busy_start_cout", cout, 1'b0);
    begin
      int extra;
      extra = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (done) extra++;
      end
      check("busy_start_no_extra_done", extra, 0);
    end

    // Reset mid-operation, with start held through the reset edge
    do_start(1'b0, 16'h000A, 16'h0001, 1'b1);
    tick();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_sum", sum, 16'h0000);
    check("mid_rst_cout", cout, 1'b0);
    check("mid_rst_inv", invalid, 1'b0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    check("mid_rst_start_ignored", busy, 1'b0);
    run_op("after_rst", 1'b0, 16'h2500, 16'h2500, 1'b0, 16'h5000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
